// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller holding the architectural HI/LO registers.
//
// A mult/multu or div/divu accepted in IDLE computes its 64-bit result at once into
// temp_q. The unit then stays busy for MULT_CYCLES or DIV_CYCLES cycles to model the
// latency of a multi-cycle datapath. HI/LO are updated on the edge that ends the busy
// window, so new values are visible in the first cycle that busy is low.
// mthi/mtlo write HI/LO directly and never raise busy.
//
// Optional feature: define MDU_DIV_EN to build the divider. When it is undefined,
// no divider logic exists and div/divu behave as no-ops.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (>= 1)
//   DIV_CYCLES   busy cycles for div/divu (>= 1)
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   synchronous, active-high reset
//   start     in   E-stage MDU instruction valid
//   md_op     in   000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others no-op
//   A, B      in   forwarded rs / rt operands
//   d_md_use  in   D-stage instruction uses the MDU
//   busy      out  operation in progress (registered)
//   stall_md  out  stall request to the pipeline (combinational)
//   hi, lo    out  architectural HI / LO registers
module mdu_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        d_md_use,
   output logic        busy,
   output logic        stall_md,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e      state_q;
   logic [15:0] cnt_q;
   logic [63:0] temp_q;
   logic        wr_q;    // commit temp_q at completion; cleared for divide by zero
   logic        busy_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   logic        is_mul;
   logic        is_div;
   logic        start_muldiv;

   assign is_mul = (md_op[2:1] == 2'b00);

`ifdef MDU_DIV_EN
   assign is_div = (md_op[2:1] == 2'b01);
`else
   assign is_div = 1'b0;
`endif

   assign start_muldiv = start & (is_mul | is_div);
   assign stall_md     = d_md_use & (start_muldiv | busy_q);

   // Multiplier: the low 64 bits of the product of the sign- or zero-extended operands
   // are the exact signed / unsigned 64-bit product.
   logic [63:0] a_ext;
   logic [63:0] b_ext;
   logic [63:0] prod;

   always_comb begin
      a_ext = md_op[0] ? {32'b0, A} : {{32{A[31]}}, A};
      b_ext = md_op[0] ? {32'b0, B} : {{32{B[31]}}, B};
      prod  = a_ext * b_ext;
   end

   // Divider result: {remainder, quotient}; div_ok is low for a zero divisor.
   logic [63:0] div_res;
   logic        div_ok;

`ifdef MDU_DIV_EN
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quot;
   logic [31:0] rem;

   // Divide magnitudes, then restore signs: quotient truncates toward zero and the
   // remainder follows the dividend.
   always_comb begin
      a_neg   = ~md_op[0] & A[31];
      b_neg   = ~md_op[0] & B[31];
      a_mag   = a_neg ? (32'd0 - A) : A;
      b_mag   = b_neg ? (32'd0 - B) : B;
      div_ok  = (B != 32'd0);
      q_mag   = div_ok ? (a_mag / b_mag) : 32'd0;
      r_mag   = div_ok ? (a_mag % b_mag) : 32'd0;
      quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      rem     = a_neg ? (32'd0 - r_mag) : r_mag;
      div_res = {rem, quot};
   end
`else
   assign div_res = 64'd0;
   assign div_ok  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 16'd0;
         temp_q  <= 64'd0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  if (is_mul) begin
                     temp_q  <= prod;
                     cnt_q   <= 16'(MULT_CYCLES);
                     wr_q    <= 1'b1;
                     busy_q  <= 1'b1;
                     state_q <= StRun;
                  end else if (is_div) begin
                     temp_q  <= div_res;
                     cnt_q   <= 16'(DIV_CYCLES);
                     wr_q    <= div_ok;
                     busy_q  <= 1'b1;
                     state_q <= StRun;
                  end else if (md_op == 3'b100) begin
                     hi_q <= A;
                  end else if (md_op == 3'b101) begin
                     lo_q <= A;
                  end
               end
            end
            StRun: begin
               // start is ignored here; only the countdown advances.
               cnt_q <= cnt_q - 16'd1;
               if (cnt_q == 16'd1) begin
                  if (wr_q) begin
                     hi_q <= temp_q[63:32];
                     lo_q <= temp_q[31:0];
                  end
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl (default parameters).
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        d_md_use;
   logic        busy;
   logic        stall_md;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_cmp  = 0;
   int n_fail = 0;

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .md_op    (md_op),
      .A        (A),
      .B        (B),
      .d_md_use (d_md_use),
      .busy     (busy),
      .stall_md (stall_md),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      md_op = op;
      A     = a;
      B     = b;
      step();
      start = 1'b0;
   endtask

   // Counts sampled busy cycles; returns in the first cycle busy is low (bounded).
   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         step();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: got %b want 0", busy);
      end
      n_cmp++;
      if (hi !== 32'd0 || lo !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_hilo: got hi=%h lo=%h want 0/0", hi, lo);
      end
      n_cmp++;
      if (stall_md !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_stall: got %b want 0", stall_md);
      end
   endtask

   task automatic test_mult();
      int n;
      issue(3'b000, 32'hFFFF_FFFD, 32'd4);
      count_busy(n);
      n_cmp++;
      if (n != 5) begin
         n_fail++;
         $display("FAIL mult_busy_len: got %0d want 5", n);
      end
      n_cmp++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF4) begin
         n_fail++;
         $display("FAIL mult_result: got hi=%h lo=%h want ffffffff/fffffff4", hi, lo);
      end
   endtask

   task automatic test_stall();
      int n;
      int n_stall;
      d_md_use = 1'b1;
      start    = 1'b1;
      md_op    = 3'b001;
      A        = 32'hFFFF_FFFF;
      B        = 32'd2;
      #1;
      n_cmp++;
      if (stall_md !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_start_cycle: got %b want 1", stall_md);
      end
      step();
      start   = 1'b0;
      n       = 0;
      n_stall = 0;
      while (busy === 1'b1 && n < 100) begin
         if (stall_md === 1'b1) n_stall++;
         n++;
         step();
      end
      n_cmp++;
      if (n != 5 || n_stall != 5) begin
         n_fail++;
         $display("FAIL stall_busy_cycles: got busy=%0d stall=%0d want 5/5", n, n_stall);
      end
      n_cmp++;
      if (stall_md !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_after_busy: got %b want 0", stall_md);
      end
      n_cmp++;
      if (hi !== 32'd1 || lo !== 32'hFFFF_FFFE) begin
         n_fail++;
         $display("FAIL multu_result: got hi=%h lo=%h want 00000001/fffffffe", hi, lo);
      end
      d_md_use = 1'b0;
   endtask

   task automatic test_mthi_mtlo();
      issue(3'b100, 32'h1234_5678, 32'd0);
      n_cmp++;
      if (hi !== 32'h1234_5678 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mthi: got hi=%h busy=%b want 12345678/0", hi, busy);
      end
      issue(3'b101, 32'h0BAD_F00D, 32'd0);
      n_cmp++;
      if (lo !== 32'h0BAD_F00D || hi !== 32'h1234_5678 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mtlo: got hi=%h lo=%h busy=%b want 12345678/0badf00d/0", hi, lo, busy);
      end
   endtask

   // mthi issued mid-operation must be dropped and must not stretch the busy window.
   task automatic test_ignore_in_run();
      int n;
      issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         if (n == 2) begin
            start = 1'b1;
            md_op = 3'b100;
            A     = 32'hDEAD_BEEF;
         end
         n++;
         step();
         start = 1'b0;
      end
      n_cmp++;
      if (n != 5) begin
         n_fail++;
         $display("FAIL ignore_busy_len: got %0d want 5", n);
      end
      n_cmp++;
      if (hi !== 32'd0 || lo !== 32'd1) begin
         n_fail++;
         $display("FAIL ignore_result: got hi=%h lo=%h want 00000000/00000001", hi, lo);
      end
   endtask

   task automatic test_reserved();
      d_md_use = 1'b1;
      start    = 1'b1;
      md_op    = 3'b110;
      A        = 32'h5555_5555;
      #1;
      n_cmp++;
      if (stall_md !== 1'b0) begin
         n_fail++;
         $display("FAIL reserved_stall: got %b want 0", stall_md);
      end
      step();
      md_op = 3'b111;
      step();
      start    = 1'b0;
      d_md_use = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd1) begin
         n_fail++;
         $display("FAIL reserved_noop: got busy=%b hi=%h lo=%h want 0/00000000/00000001",
                  busy, hi, lo);
      end
   endtask

`ifdef MDU_DIV_EN
   task automatic test_div();
      int n;
      issue(3'b011, 32'd7, 32'd2);
      count_busy(n);
      n_cmp++;
      if (n != 10 || hi !== 32'd1 || lo !== 32'd3) begin
         n_fail++;
         $display("FAIL divu: got n=%0d hi=%h lo=%h want 10/00000001/00000003", n, hi, lo);
      end
      issue(3'b010, 32'hFFFF_FFF9, 32'd2);
      count_busy(n);
      n_cmp++;
      if (n != 10 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
         n_fail++;
         $display("FAIL div_signed: got n=%0d hi=%h lo=%h want 10/ffffffff/fffffffd", n, hi, lo);
      end
      issue(3'b100, 32'hA, 32'd0);
      issue(3'b101, 32'hB, 32'd0);
      issue(3'b010, 32'd99, 32'd0);
      count_busy(n);
      n_cmp++;
      if (n != 10 || hi !== 32'hA || lo !== 32'hB) begin
         n_fail++;
         $display("FAIL div_by_zero: got n=%0d hi=%h lo=%h want 10/0000000a/0000000b", n, hi, lo);
      end
   endtask
`else
   // Divider not built: div/divu must neither stall nor change anything.
   task automatic test_div();
      issue(3'b100, 32'hA, 32'd0);
      issue(3'b101, 32'hB, 32'd0);
      d_md_use = 1'b1;
      start    = 1'b1;
      md_op    = 3'b010;
      A        = 32'd7;
      B        = 32'd2;
      #1;
      n_cmp++;
      if (stall_md !== 1'b0) begin
         n_fail++;
         $display("FAIL div_disabled_stall: got %b want 0", stall_md);
      end
      step();
      md_op = 3'b011;
      step();
      start    = 1'b0;
      d_md_use = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || hi !== 32'hA || lo !== 32'hB) begin
         n_fail++;
         $display("FAIL div_disabled_noop: got busy=%b hi=%h lo=%h want 0/0000000a/0000000b",
                  busy, hi, lo);
      end
   endtask
`endif

   task automatic test_reset_mid_op();
      logic seen42;
      issue(3'b000, 32'd6, 32'd7);  // now in busy cycle 1
      step();                       // busy cycle 2
      step();                       // busy cycle 3
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_mid_op: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
      end
      seen42 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (lo === 32'd42 || busy !== 1'b0) seen42 = 1'b1;
         step();
      end
      n_cmp++;
      if (seen42 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_discard: got stale result/busy=%b want 0", seen42);
      end
   endtask

   task automatic test_reset_priority();
      reset = 1'b1;
      start = 1'b1;
      md_op = 3'b100;
      A     = 32'hCAFE_0001;
      step();
      md_op = 3'b000;
      A     = 32'd6;
      B     = 32'd7;
      step();
      reset = 1'b0;
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_priority: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
      end
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      md_op    = 3'b000;
      A        = 32'd0;
      B        = 32'd0;
      d_md_use = 1'b0;
      step();
      test_reset();
      test_mult();
      test_stall();
      test_mthi_mtlo();
      test_ignore_in_run();
      test_reserved();
      test_div();
      test_reset_mid_op();
      test_reset_priority();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  E-stage MDU instruction valid, sampled each rising edge.
REQ-006 SHALL have port md_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others no-op.
REQ-007 SHALL have port A  input  32  forwarded rs operand.
REQ-008 SHALL have port B  input  32  forwarded rt operand.
REQ-009 SHALL have port d_md_use  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-010 SHALL have port busy  output  1  operation in progress.
REQ-011 SHALL have port stall_md  output  1  stall request OR-ed into the pipeline stall unit.
REQ-012 SHALL have port hi  output  32  architectural HI register.
REQ-013 SHALL have port lo  output  32  architectural LO register.

Function
REQ-014 SHALL implement states IDLE and RUN with a down-counter cnt; busy = (state == RUN), registered.
REQ-015 IDLE, start=1, md_op mult/multu: SHALL latch the 64-bit product into a temp register, load cnt=MULT_CYCLES, enter RUN.
REQ-016 IDLE, start=1, md_op div/divu: SHALL latch the quotient into temp low and the remainder into temp high, load cnt=DIV_CYCLES, enter RUN.
REQ-017 RUN: SHALL decrement cnt each edge. At the edge where cnt==1, SHALL write hi<=temp[63:32] and lo<=temp[31:0], then return to IDLE.
REQ-018 busy SHALL be high for exactly N cycles after the start edge. New hi/lo SHALL be visible in the first cycle that busy is low.
REQ-019 mult and div SHALL be two's-complement. div SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend. multu and divu SHALL be unsigned.
REQ-020 Divide by zero SHALL run the full DIV_CYCLES with busy high, and SHALL leave hi/lo unchanged at completion.
REQ-021 IDLE, start=1, md_op mthi/mtlo: SHALL write A to hi/lo at that edge, with no busy.
REQ-022 start=1 while in RUN SHALL be ignored: no state, counter or hi/lo change.
REQ-023 start=1 with a reserved md_op SHALL be a no-op.
REQ-024 stall_md SHALL be combinational: d_md_use & (start_muldiv | busy), where start_muldiv = start & md_op in {000..011}.

Reset
REQ-025 reset=1 at a rising edge SHALL force state=IDLE, cnt=0, busy=0, hi=0, lo=0, temp=0, including mid-operation; the pending result SHALL be discarded.
REQ-026 reset SHALL take priority over start in the same cycle.

Configuration
REQ-027 Macro MDU_DIV_EN defined: div/divu SHALL behave per REQ-016/019/020.
REQ-028 Macro MDU_DIV_EN undefined: no divider logic SHALL be synthesized; div/divu SHALL be no-ops (no busy, hi/lo unchanged, stall_md not raised for them).

Verification
REQ-029 mult A=0xFFFFFFFD, B=4: busy SHALL be high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF4.
REQ-030 divu A=7, B=2 SHALL give lo=3, hi=1 after 10 busy cycles. div A=0xFFFFFFF9, B=2 SHALL give lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-031 start=1 (multu) with d_md_use=1: stall_md SHALL be high in the start cycle and all 5 busy cycles, and low in the cycle busy falls.
REQ-032 mthi A=0x12345678: hi SHALL be 0x12345678 after 1 edge, and busy SHALL stay 0.
REQ-033 reset asserted in the 3rd busy cycle of mult 6*7: next edge SHALL give busy=0, hi=lo=0, and 42 SHALL never appear.
REQ-034 div B=0 with prior hi=0xA, lo=0xB: busy SHALL be high 10 cycles, then hi=0xA, lo=0xB.
